aes_inv_core: RTL

Iterative AES decryption core and the inverse counterpart of the encryption core. It takes a 128-, 192- or 256-bit key and a 128-bit ciphertext, and produces the plaintext using the FIPS-197 inverse cipher. Because the inverse cipher consumes round keys last-first, the core expands the whole key schedule into an internal buffer first, then runs one inverse round per cycle. It sits beside the encryption core behind the same ce/done load protocol and uses the same byte/word packing: w[0] = [127:96] … w[3] = [31:0], and byte S(r,c) = bits [127-8(4c+r) -: 8].

---
 rtl/aes_pkg.sv | 84 ++++++++
 rtl/aes_inv_round.sv | 59 +++++
 rtl/aes_inv_core.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the encryption and decryption cores.
// Contents: FSM state type, forward/inverse S-box tables and lookups,
// GF(2^8) arithmetic (xtime, gf_mul), round constants, and nk()/nr()
// key-size helpers.
package aes_pkg;

  typedef enum logic [1:0] {LOAD, EXPAND, DECRYPT, DONE} state_t;

  // Entry 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TAB[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Round constant for key-schedule step n (1-based).
  function automatic logic [7:0] rcon(input int n);
    case (n)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int nk(input int k);
    return k / 32;
  endfunction

  function automatic int nr(input int k);
    return k / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: combinational inverse AES round.
// Ports: state_in  - current 128-bit state
//        round_key - round key added after InvSubBytes
//        last      - 1 skips InvMixColumns (final round)
//        state_out - resulting state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // InvShiftRows: row r rotates right by r columns.
  always_comb begin
    shifted = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  // InvSubBytes on every byte.
  always_comb begin
    subbed = 128'h0;
    for (int i = 0; i < 16; i++) begin
      subbed[8*i +: 8] = inv_sbox(shifted[8*i +: 8]);
    end
  end

  assign keyed = subbed ^ round_key;

  // InvMixColumns on each column of the keyed state.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = 128'h0;
    a0 = 8'h00; a1 = 8'h00; a2 = 8'h00; a3 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[127-32*c -: 8];
      a1 = keyed[119-32*c -: 8];
      a2 = keyed[111-32*c -: 8];
      a3 = keyed[103-32*c -: 8];
      mixed[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      mixed[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      mixed[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      mixed[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
  end

  assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES decryption core (K = 128/192/256).
// The full key schedule is expanded into an internal word buffer (4 words
// per cycle), then one inverse round runs per cycle using round keys from
// last to first.
// Ports: clk, reset (sync, active-high)
//        ce         - load enable; key/ciphertext captured while high
//        key        - cipher key, w[0] in the top 32 bits
//        ciphertext - input block
//        done       - plaintext valid, held until ce rises or reset
//        plaintext  - decrypted block, updated only when done rises
module aes_inv_core
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  logic [K-1:0]   key,
  input  logic [127:0]   ciphertext,
  output logic           done,
  output logic [127:0]   plaintext
);

  localparam int NK = nk(K);
  localparam int NR = nr(K);
  localparam int NW = 4 * (NR + 1);
  localparam int E  = (NW - NK + 3) / 4;

  if (K != 128 && K != 192 && K != 256) begin : g_bad_k
    $error("aes_inv_core: K must be 128, 192 or 256");
  end

  state_t       fsm;
  logic         loaded;
  logic [5:0]   widx;
  logic [3:0]   exp_cnt;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [31:0]  w [NW];
  logic [31:0]  nw [4];
  logic [127:0] rk;
  logic [127:0] round_out;

  // Key expansion: next four schedule words, chained within the cycle.
  // Nk >= 4, so w[i-Nk] always comes from the buffer.
  always_comb begin
    logic [5:0]  idx;
    logic [31:0] prev;
    logic [31:0] temp;
    int          m;
    for (int j = 0; j < 4; j++) begin
      idx = widx + 6'(j);
      if (j == 0) prev = w[widx - 6'd1];
      else        prev = nw[(j == 0) ? 0 : j - 1];
      m = int'(idx) % NK;
      if (m == 0) begin
        temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(int'(idx) / NK), 24'h000000};
      end else if (NK == 8 && m == 4) begin
        temp = sub_word(prev);
      end else begin
        temp = prev;
      end
      nw[j] = w[idx - 6'(NK)] ^ temp;
    end
  end

  assign rk = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};

  aes_inv_round u_round (
    .state_in  (st),
    .round_key (rk),
    .last      (rnd == 4'd0),
    .state_out (round_out)
  );

  // Key buffer: key words on load, expanded words during EXPAND.
  always_ff @(posedge clk) begin
    if (ce) begin
      for (int m = 0; m < NK; m++) w[m] <= key[K-1-32*m -: 32];
    end else if (fsm == EXPAND) begin
      for (int j = 0; j < 4; j++) begin
        if (int'(widx) + j < NW) w[widx + 6'(j)] <= nw[j];
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= LOAD;
      loaded    <= 1'b0;
      widx      <= 6'd0;
      exp_cnt   <= 4'd0;
      rnd       <= 4'd0;
      st        <= 128'h0;
      done      <= 1'b0;
      plaintext <= 128'h0;
    end else if (ce) begin
      // A load from any state restarts the core; partial work is dropped.
      fsm    <= LOAD;
      loaded <= 1'b1;
      st     <= ciphertext;
      done   <= 1'b0;
    end else begin
      case (fsm)
        LOAD: begin
          // Start only after an actual load, not straight out of reset.
          if (loaded) begin
            fsm     <= EXPAND;
            loaded  <= 1'b0;
            widx    <= 6'(NK);
            exp_cnt <= 4'd0;
          end
        end
        EXPAND: begin
          widx    <= widx + 6'd4;
          exp_cnt <= exp_cnt + 4'd1;
          if (exp_cnt == 4'(E - 1)) begin
            fsm <= DECRYPT;
            rnd <= 4'(NR);
          end
        end
        DECRYPT: begin
          if (rnd == 4'(NR)) begin
            st  <= st ^ rk;
            rnd <= rnd - 4'd1;
          end else begin
            st <= round_out;
            if (rnd == 4'd0) begin
              fsm       <= DONE;
              done      <= 1'b1;
              plaintext <= round_out;
            end else begin
              rnd <= rnd - 4'd1;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          fsm  <= LOAD;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
